// File: rtl/approx_adder_pipe.sv
// Two-stage lower-part-OR approximate adder. The exact sum and the absolute error
// travel with each result, and saturating running accuracy statistics are kept.
module approx_adder_pipe #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_BITS = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned ACC_W       = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode_exact,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic [WIDTH:0]   sum_exact,
    output logic [WIDTH:0]   abs_err,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH:0]   max_err,
    output logic [ACC_W-1:0] err_acc
);

    localparam int unsigned K = APPROX_BITS;

    logic             s1_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             mode_q;

    logic             s2_valid_q;
    logic [WIDTH:0]   sum_q;
    logic [WIDTH:0]   sum_exact_q;
    logic [WIDTH:0]   abs_err_q;

    logic             s2_adv;
    logic             in_fire;
    logic             out_fire;

    logic [WIDTH:0]   exact_c;
    logic [WIDTH:0]   approx_c;
    logic [WIDTH:0]   sel_c;
    logic [WIDTH:0]   err_c;

    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH:0]   max_err_q, max_err_d;
    logic [ACC_W-1:0] err_acc_q, err_acc_d;
    logic [ACC_W:0]   acc_sum;

    // in_ready is held low during reset so nothing is accepted in that cycle.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !rst && (!s1_valid_q || s2_adv);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;

    assign exact_c = {1'b0, a_q} + {1'b0, b_q};

    if (K == 0) begin : g_exact_only
        assign approx_c = exact_c;
    end else begin : g_approx
        logic [K-1:0]     lo;
        logic             cin;
        logic [WIDTH-K:0] hi;

        assign lo       = a_q[K-1:0] | b_q[K-1:0];
        assign cin      = a_q[K-1] & b_q[K-1];
        assign hi       = {1'b0, a_q[WIDTH-1:K]} + {1'b0, b_q[WIDTH-1:K]} +
                          {{(WIDTH-K){1'b0}}, cin};
        assign approx_c = {hi, lo};
    end

    // Approximation can land above or below the exact sum.
    assign sel_c = mode_q ? exact_c : approx_c;
    assign err_c = (sel_c > exact_c) ? (sel_c - exact_c) : (exact_c - sel_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            s2_valid_q  <= 1'b0;
            sum_q       <= '0;
            sum_exact_q <= '0;
            abs_err_q   <= '0;
        end else begin
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                a_q        <= a;
                b_q        <= b;
                mode_q     <= mode_exact;
            end else if (s1_valid_q && s2_adv) begin
                s1_valid_q <= 1'b0;
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    sum_q       <= sel_c;
                    sum_exact_q <= exact_c;
                    abs_err_q   <= err_c;
                end
            end
        end
    end

    assign acc_sum = {1'b0, err_acc_q} + (ACC_W + 1)'(abs_err_q);

    // Clear takes priority over a coincident output transfer.
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        max_err_d    = max_err_q;
        err_acc_d    = err_acc_q;
        if (stat_clr) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            max_err_d    = '0;
            err_acc_d    = '0;
        end else if (out_fire) begin
            if (!(&sample_cnt_q)) begin
                sample_cnt_d = sample_cnt_q + CNT_W'(1);
            end
            if ((abs_err_q != '0) && !(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (abs_err_q > max_err_q) begin
                max_err_d = abs_err_q;
            end
            err_acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            max_err_q    <= '0;
            err_acc_q    <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            max_err_q    <= max_err_d;
            err_acc_q    <= err_acc_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign sum        = sum_q;
    assign sum_exact  = sum_exact_q;
    assign abs_err    = abs_err_q;
    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign max_err    = max_err_q;
    assign err_acc    = err_acc_q;

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Randomised and directed bench for approx_adder_pipe: three builds (default,
// narrow counters, k=0) share stimulus and are scored against an arithmetic model.
module tb_approx_adder_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       mode_exact = 1'b0;
    logic       stat_clr = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic        in_ready, out_valid;
    logic [8:0]  sum, sum_exact, abs_err, max_err;
    logic [15:0] sample_cnt, err_cnt;
    logic [23:0] err_acc;

    logic        s_in_ready, s_out_valid;
    logic [8:0]  s_sum, s_sum_exact, s_abs_err, s_max_err, s_err_acc;
    logic [3:0]  s_sample_cnt, s_err_cnt;

    logic        z_in_ready, z_out_valid;
    logic [8:0]  z_sum, z_sum_exact, z_abs_err, z_max_err;
    logic [15:0] z_sample_cnt, z_err_cnt;
    logic [23:0] z_err_acc;

    approx_adder_pipe #(.WIDTH(8), .APPROX_BITS(4), .CNT_W(16), .ACC_W(24)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .mode_exact(mode_exact), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .sum_exact(sum_exact), .abs_err(abs_err), .stat_clr(stat_clr),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .max_err(max_err), .err_acc(err_acc)
    );

    approx_adder_pipe #(.WIDTH(8), .APPROX_BITS(4), .CNT_W(4), .ACC_W(9)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b),
        .mode_exact(mode_exact), .out_valid(s_out_valid), .out_ready(out_ready),
        .sum(s_sum), .sum_exact(s_sum_exact), .abs_err(s_abs_err), .stat_clr(stat_clr),
        .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt), .max_err(s_max_err),
        .err_acc(s_err_acc)
    );

    approx_adder_pipe #(.WIDTH(8), .APPROX_BITS(0), .CNT_W(16), .ACC_W(24)) dut_k0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready), .a(a), .b(b),
        .mode_exact(mode_exact), .out_valid(z_out_valid), .out_ready(out_ready),
        .sum(z_sum), .sum_exact(z_sum_exact), .abs_err(z_abs_err), .stat_clr(stat_clr),
        .sample_cnt(z_sample_cnt), .err_cnt(z_err_cnt), .max_err(z_max_err),
        .err_acc(z_err_acc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the lower-part-OR rule.
    function automatic int ref_sum(input int k, input int va, input int vb, input bit ex);
        int m, lo, c, hi;
        if (ex || k == 0) return va + vb;
        m  = 1 << k;
        lo = (va | vb) % m;
        c  = ((va >> (k - 1)) & 1) & ((vb >> (k - 1)) & 1);
        hi = (va >> k) + (vb >> k) + c;
        return hi * m + lo;
    endfunction

    function automatic int ref_err(input int k, input int va, input int vb, input bit ex);
        int s, e;
        s = ref_sum(k, va, vb, ex);
        e = va + vb;
        return (s > e) ? s - e : e - s;
    endfunction

    typedef struct {int va; int vb; bit ex;} txn_t;
    txn_t   q[$];
    longint m_smp[2], m_ecn[2], m_max[2], m_acc[2];
    longint cmax[2] = '{65535, 15};
    longint amax[2] = '{24'hFFFFFF, 511};
    longint z_smp;
    bit     hold_pend = 1'b0;
    logic [8:0] hold_sum, hold_exact, hold_err;

    task automatic zero_model();
        for (int i = 0; i < 2; i++) begin
            m_smp[i] = 0; m_ecn[i] = 0; m_max[i] = 0; m_acc[i] = 0;
        end
        z_smp = 0;
    endtask

    initial zero_model();

    always @(negedge clk) begin
        txn_t t;
        int   e;
        bit   exp_rdy;
        exp_rdy = !rst && !(q.size() >= 2 && !out_ready);
        check_eq("in_ready", in_ready, exp_rdy);
        check_eq("in_ready_sat", s_in_ready, exp_rdy);
        check_eq("in_ready_k0", z_in_ready, exp_rdy);
        if (q.size() == 0) begin
            check_eq("idle_out_valid", out_valid, 0);
            check_eq("idle_out_valid_sat", s_out_valid, 0);
            check_eq("idle_out_valid_k0", z_out_valid, 0);
        end
        if (q.size() == 2) check_eq("full_out_valid", out_valid, 1);
        check_eq("sample_cnt", sample_cnt, m_smp[0]);
        check_eq("err_cnt", err_cnt, m_ecn[0]);
        check_eq("max_err", max_err, m_max[0]);
        check_eq("err_acc", err_acc, m_acc[0]);
        check_eq("sample_cnt_sat", s_sample_cnt, m_smp[1]);
        check_eq("err_cnt_sat", s_err_cnt, m_ecn[1]);
        check_eq("max_err_sat", s_max_err, m_max[1]);
        check_eq("err_acc_sat", s_err_acc, m_acc[1]);
        check_eq("sample_cnt_k0", z_sample_cnt, z_smp);
        check_eq("err_cnt_k0", z_err_cnt, 0);
        check_eq("max_err_k0", z_max_err, 0);
        check_eq("err_acc_k0", z_err_acc, 0);
        if (hold_pend) begin
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_sum", sum, hold_sum);
            check_eq("stall_exact", sum_exact, hold_exact);
            check_eq("stall_err", abs_err, hold_err);
        end
        hold_pend  = !rst && out_valid && !out_ready;
        hold_sum   = sum;
        hold_exact = sum_exact;
        hold_err   = abs_err;
        if (rst) begin
            q.delete();
            zero_model();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check_eq("unexpected_out", out_valid, 0);
                end else begin
                    t = q.pop_front();
                    e = ref_err(4, t.va, t.vb, t.ex);
                    check_eq("sum", sum, ref_sum(4, t.va, t.vb, t.ex));
                    check_eq("sum_exact", sum_exact, t.va + t.vb);
                    check_eq("abs_err", abs_err, e);
                    check_eq("sum_sat", s_sum, ref_sum(4, t.va, t.vb, t.ex));
                    check_eq("sum_exact_sat", s_sum_exact, t.va + t.vb);
                    check_eq("abs_err_sat", s_abs_err, e);
                    check_eq("sum_k0", z_sum, ref_sum(0, t.va, t.vb, t.ex));
                    check_eq("sum_exact_k0", z_sum_exact, t.va + t.vb);
                    check_eq("abs_err_k0", z_abs_err, ref_err(0, t.va, t.vb, t.ex));
                    if (!stat_clr) begin
                        for (int i = 0; i < 2; i++) begin
                            m_smp[i] = (m_smp[i] + 1 > cmax[i]) ? cmax[i] : m_smp[i] + 1;
                            if (e != 0)
                                m_ecn[i] = (m_ecn[i] + 1 > cmax[i]) ? cmax[i] : m_ecn[i] + 1;
                            m_acc[i] = (m_acc[i] + e > amax[i]) ? amax[i] : m_acc[i] + e;
                            if (e > m_max[i]) m_max[i] = e;
                        end
                        z_smp = (z_smp + 1 > 65535) ? 65535 : z_smp + 1;
                    end
                end
            end
            if (stat_clr) zero_model();
            if (in_valid && in_ready) q.push_back('{int'(a), int'(b), mode_exact});
        end
    end

    task automatic run_vec(input logic [7:0] va, input logic [7:0] vb, input bit ex,
                           input logic [8:0] es, input logic [8:0] ee, input logic [8:0] er);
        in_valid = 1'b1; a = va; b = vb; mode_exact = ex; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check_eq("lat_early", out_valid, 0);
        @(negedge clk);
        check_eq("lat_valid", out_valid, 1);
        check_eq("dir_sum", sum, es);
        check_eq("dir_exact", sum_exact, ee);
        check_eq("dir_err", abs_err, er);
        @(posedge clk); #1;
    endtask

    task automatic clr_pulse();
        stat_clr = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;
    endtask

    logic [7:0] sa[5] = '{8'hED, 8'hDE, 8'h0F, 8'h37, 8'hA5};
    logic [7:0] sb[5] = '{8'h6D, 8'hC2, 8'h00, 8'h9C, 8'h5A};

    initial begin
        int  idx, n;
        bit  seen_drop, fire;
        // Reset, with in_valid asserted to show it is ignored.
        in_valid = 1'b1; a = 8'h55; b = 8'h55;
        @(negedge clk); @(negedge clk);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_sum", sum, 0);
        @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", in_ready, 1);
        check_eq("post_rst_out_valid", out_valid, 0);
        @(posedge clk); #1;

        run_vec(8'hED, 8'h6D, 1'b0, 9'h15D, 9'h15A, 9'd3);
        run_vec(8'hDE, 8'hC2, 1'b0, 9'h19E, 9'h1A0, 9'd2);
        run_vec(8'h0F, 8'h00, 1'b0, 9'h00F, 9'h00F, 9'd0);
        @(negedge clk);
        check_eq("stat3_sample", sample_cnt, 3);
        check_eq("stat3_errcnt", err_cnt, 2);
        check_eq("stat3_max", max_err, 3);
        check_eq("stat3_acc", err_acc, 5);

        // Clear coincident with a 4th output transfer.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; a = 8'hED; b = 8'h6D; mode_exact = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1; stat_clr = 1'b1;
        @(posedge clk); #1 stat_clr = 1'b0;
        @(negedge clk);
        check_eq("clr_sample", sample_cnt, 0);
        check_eq("clr_errcnt", err_cnt, 0);
        check_eq("clr_max", max_err, 0);
        check_eq("clr_acc", err_acc, 0);
        @(posedge clk); #1;

        run_vec(8'hDE, 8'hC2, 1'b1, 9'h1A0, 9'h1A0, 9'd0);

        // Back-to-back stream with a 3-cycle downstream stall.
        clr_pulse();
        idx = 0; seen_drop = 1'b0;
        for (int c = 0; c < 40 && !(idx == 5 && c > 8); c++) begin
            in_valid = (idx < 5);
            if (idx < 5) begin a = sa[idx]; b = sb[idx]; end
            mode_exact = 1'b0;
            out_ready = !(c >= 2 && c < 5);
            @(negedge clk);
            if (in_valid && !in_ready) seen_drop = 1'b1;
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("stream_accepted", idx, 5);
        check_eq("stream_in_ready_drop", seen_drop, 1);
        check_eq("stream_sample", sample_cnt, 5);

        // Saturation: each (x8, y8) pair has an error of exactly 8.
        @(posedge clk); #1;
        clr_pulse();
        n = 0;
        for (int c = 0; c < 300 && n < 80; c++) begin
            in_valid = 1'b1; mode_exact = 1'b0; out_ready = 1'b1;
            a = 8'(($urandom % 16) * 16 + 8);
            b = 8'(($urandom % 16) * 16 + 8);
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) n++;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("sat_sample", s_sample_cnt, 15);
        check_eq("sat_acc", s_err_acc, 511);
        check_eq("main_sample80", sample_cnt, 80);
        check_eq("main_acc640", err_acc, 640);

        // Reset with both stages occupied.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h12; b = 8'h34;
        @(posedge clk); #1 a = 8'h56; b = 8'h78;
        @(posedge clk); #1 rst = 1'b1; a = 8'h9A; b = 8'hBC;
        @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("rst2_out_valid", out_valid, 0);
        check_eq("rst2_sum", sum, 0);
        check_eq("rst2_sample", sample_cnt, 0);
        check_eq("rst2_acc", err_acc, 0);
        check_eq("rst2_max", max_err, 0);
        check_eq("rst2_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst2_no_stale", out_valid, 0);
        end

        // Random traffic, random back-pressure and occasional clears.
        @(posedge clk); #1;
        for (int c = 0; c < 600; c++) begin
            in_valid   = ($urandom % 4) != 0;
            out_ready  = ($urandom % 3) != 0;
            mode_exact = ($urandom % 4) == 0;
            stat_clr   = ($urandom % 50) == 0;
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; stat_clr = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        check_eq("drain_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
